// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter serialising ALU, MUL/DIV and FPU results onto one register file write port
module wb_arbiter #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic [4:0]       alu_addr,
    input  logic [XLEN-1:0]  alu_data,
    input  logic             md_valid,
    output logic             md_ready,
    input  logic [4:0]       md_addr,
    input  logic [XLEN-1:0]  md_data,
    input  logic             fpu_valid,
    output logic             fpu_ready,
    input  logic [4:0]       fpu_addr,
    input  logic [XLEN-1:0]  fpu_data,
    input  logic             fpu_is_fp,
    output logic             write,
    output logic [4:0]       w1_addr,
    output logic [XLEN-1:0]  inp_data,
    output logic             sel_i_f,
    output logic [CNT_W-1:0] retired_cnt
);

    logic             write_q,    write_d;
    logic [4:0]       w1_addr_q,  w1_addr_d;
    logic [XLEN-1:0]  inp_data_q, inp_data_d;
    logic             sel_i_f_q,  sel_i_f_d;
    logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
    logic             rr_ptr_q,   rr_ptr_d;

    logic grant_alu, grant_md, grant_fpu, grant_any;

    // Fixed ALU priority (it cannot stall); MUL/DIV vs FPU alternate only when both are waiting
    always_comb begin
        grant_alu = alu_valid;
        grant_md  = ~alu_valid & md_valid  & (~fpu_valid | ~rr_ptr_q);
        grant_fpu = ~alu_valid & fpu_valid & (~md_valid  |  rr_ptr_q);
        grant_any = grant_alu | grant_md | grant_fpu;
        md_ready  = rst & grant_md;
        fpu_ready = rst & grant_fpu;
    end

    // Next output-stage contents: capture the granted result, hold fields when idle, drop x0 writes
    always_comb begin
        w1_addr_d     = w1_addr_q;
        inp_data_d    = inp_data_q;
        sel_i_f_d     = sel_i_f_q;
        rr_ptr_d      = rr_ptr_q;
        if (grant_alu) begin
            w1_addr_d  = alu_addr;
            inp_data_d = alu_data;
            sel_i_f_d  = 1'b0;
        end else if (grant_md) begin
            w1_addr_d  = md_addr;
            inp_data_d = md_data;
            sel_i_f_d  = 1'b0;
            rr_ptr_d   = 1'b1;
        end else if (grant_fpu) begin
            w1_addr_d  = fpu_addr;
            inp_data_d = fpu_data;
            sel_i_f_d  = fpu_is_fp;
            rr_ptr_d   = 1'b0;
        end
        // f0 is a real register; only integer x0 is hardwired to zero
        write_d       = grant_any & (sel_i_f_d | (w1_addr_d != 5'd0));
        retired_cnt_d = retired_cnt_q + CNT_W'(grant_any);
    end

    // Registered output stage; reset discards any in-flight write immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_q       <= 1'b0;
            w1_addr_q     <= 5'd0;
            inp_data_q    <= '0;
            sel_i_f_q     <= 1'b0;
            retired_cnt_q <= '0;
            rr_ptr_q      <= 1'b0;
        end else begin
            write_q       <= write_d;
            w1_addr_q     <= w1_addr_d;
            inp_data_q    <= inp_data_d;
            sel_i_f_q     <= sel_i_f_d;
            retired_cnt_q <= retired_cnt_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign write       = write_q;
    assign w1_addr     = w1_addr_q;
    assign inp_data    = inp_data_q;
    assign sel_i_f     = sel_i_f_q;
    assign retired_cnt = retired_cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter
module tb_wb_arbiter;

    localparam int XLEN  = 64;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             alu_valid = 1'b0;
    logic [4:0]       alu_addr  = '0;
    logic [XLEN-1:0]  alu_data  = '0;
    logic             md_valid  = 1'b0;
    logic             md_ready;
    logic [4:0]       md_addr   = '0;
    logic [XLEN-1:0]  md_data   = '0;
    logic             fpu_valid = 1'b0;
    logic             fpu_ready;
    logic [4:0]       fpu_addr  = '0;
    logic [XLEN-1:0]  fpu_data  = '0;
    logic             fpu_is_fp = 1'b0;
    logic             write;
    logic [4:0]       w1_addr;
    logic [XLEN-1:0]  inp_data;
    logic             sel_i_f;
    logic [CNT_W-1:0] retired_cnt;

    always #5 clk = ~clk;

    wb_arbiter #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
        .md_valid(md_valid), .md_ready(md_ready), .md_addr(md_addr), .md_data(md_data),
        .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_addr(fpu_addr), .fpu_data(fpu_data),
        .fpu_is_fp(fpu_is_fp),
        .write(write), .w1_addr(w1_addr), .inp_data(inp_data), .sel_i_f(sel_i_f),
        .retired_cnt(retired_cnt)
    );

    typedef struct packed {
        logic             wr;
        logic [4:0]       addr;
        logic [XLEN-1:0]  data;
        logic             sel;
        logic [CNT_W-1:0] cnt;
    } out_t;

    out_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic             m_rr   = 1'b0;
    logic [CNT_W-1:0] m_cnt  = '0;
    logic [4:0]       m_addr = '0;
    logic [XLEN-1:0]  m_data = '0;
    logic             m_sel  = 1'b0;
    logic             g_alu, g_md, g_fpu;

    // A stalled source must keep its result stable
    assert property (@(posedge clk) disable iff (!rst)
        (md_valid && !md_ready) |=> (!md_valid || ($stable(md_addr) && $stable(md_data))))
        else $error("FAIL src_stable_md");
    assert property (@(posedge clk) disable iff (!rst)
        (fpu_valid && !fpu_ready) |=> (!fpu_valid || ($stable(fpu_addr) && $stable(fpu_data))))
        else $error("FAIL src_stable_fpu");

    task automatic calc_grant();
        g_alu = alu_valid;
        g_md  = !alu_valid && md_valid  && (!fpu_valid || !m_rr);
        g_fpu = !alu_valid && fpu_valid && (!md_valid  ||  m_rr);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_rr = 1'b0; m_cnt = '0; m_addr = '0; m_data = '0; m_sel = 1'b0;
    endtask

    // Push the output expected one cycle after the current inputs are sampled
    task automatic predict();
        out_t e;
        calc_grant();
        if (g_alu) begin
            m_addr = alu_addr; m_data = alu_data; m_sel = 1'b0;
        end else if (g_md) begin
            m_addr = md_addr; m_data = md_data; m_sel = 1'b0; m_rr = 1'b1;
        end else if (g_fpu) begin
            m_addr = fpu_addr; m_data = fpu_data; m_sel = fpu_is_fp; m_rr = 1'b0;
        end
        e.wr = 1'b0;
        if (g_alu || g_md || g_fpu) begin
            m_cnt = m_cnt + 1'b1;
            e.wr  = m_sel || (m_addr != 5'd0);
        end
        e.addr = m_addr; e.data = m_data; e.sel = m_sel; e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        predict();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; md_valid = 1'b0; fpu_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        out_t e;
        rst = 1'b0;
        md_valid = 1'b1; fpu_valid = 1'b1; md_addr = 5'd3; fpu_addr = 5'd4;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({write, retired_cnt, md_ready, fpu_ready} !== {1'b0, {CNT_W{1'b0}}, 2'b00}) begin
                n_fail++;
                $display("FAIL reset_state: got write=%0b cnt=%0d md_ready=%0b fpu_ready=%0b, want 0 0 0 0",
                         write, retired_cnt, md_ready, fpu_ready);
            end
        end
        idle_inputs();
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({md_ready, fpu_ready} !== 2'b00) begin
                n_fail++;
                $display("FAIL idle_ready: got md_ready=%0b fpu_ready=%0b, want 0 0", md_ready, fpu_ready);
            end
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if ({write, w1_addr, inp_data, sel_i_f, retired_cnt} !== e) begin
                n_fail++;
                $display("FAIL idle_out: got wr=%0b addr=%0d data=%h sel=%0b cnt=%0d, want wr=%0b addr=%0d data=%h sel=%0b cnt=%0d",
                         write, w1_addr, inp_data, sel_i_f, retired_cnt, e.wr, e.addr, e.data, e.sel, e.cnt);
            end
        end
    endtask

    typedef struct {
        int              src;
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
        logic            is_fp;
    } wr_t;

    task automatic test_writes();
        wr_t  tbl[7];
        out_t e;
        tbl[0] = '{0, 5'd5,  64'h1234,             1'b0};
        tbl[1] = '{0, 5'd0,  64'hFF,               1'b0};
        tbl[2] = '{2, 5'd0,  64'h3FF0000000000000, 1'b1};
        tbl[3] = '{2, 5'd0,  64'hAB,               1'b0};
        tbl[4] = '{1, 5'd7,  64'h55,               1'b0};
        tbl[5] = '{1, 5'd0,  64'h66,               1'b0};
        tbl[6] = '{0, 5'd31, 64'hDEAD_BEEF_0123,   1'b0};
        for (int i = 0; i < 14; i++) begin
            idle_inputs();
            if (i % 2 == 0) begin
                case (tbl[i/2].src)
                    0: begin alu_valid = 1'b1; alu_addr = tbl[i/2].addr; alu_data = tbl[i/2].data; end
                    1: begin md_valid  = 1'b1; md_addr  = tbl[i/2].addr; md_data  = tbl[i/2].data; end
                    default: begin
                        fpu_valid = 1'b1; fpu_addr = tbl[i/2].addr; fpu_data = tbl[i/2].data;
                        fpu_is_fp = tbl[i/2].is_fp;
                    end
                endcase
            end
            #1;
            calc_grant();
            n_cmp++;
            if ({md_ready, fpu_ready} !== {g_md, g_fpu}) begin
                n_fail++;
                $display("FAIL write_ready[%0d]: got md=%0b fpu=%0b, want md=%0b fpu=%0b",
                         i, md_ready, fpu_ready, g_md, g_fpu);
            end
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if ({write, w1_addr, inp_data, sel_i_f, retired_cnt} !== e) begin
                n_fail++;
                $display("FAIL write_out[%0d]: got wr=%0b addr=%0d data=%h sel=%0b cnt=%0d, want wr=%0b addr=%0d data=%h sel=%0b cnt=%0d",
                         i, write, w1_addr, inp_data, sel_i_f, retired_cnt, e.wr, e.addr, e.data, e.sel, e.cnt);
            end
        end
        n_cmp++;
        if (retired_cnt !== 4'd7) begin
            n_fail++;
            $display("FAIL write_count: got %0d, want 7", retired_cnt);
        end
    endtask

    task automatic test_round_robin();
        int   order[4] = '{1, 2, 1, 2};
        int   md_left = 2, fpu_left = 2, k = 0, obs;
        out_t e;
        idle_inputs();
        md_valid = 1'b1; md_addr = 5'd1; md_data = 64'h100;
        fpu_valid = 1'b1; fpu_addr = 5'd2; fpu_data = 64'h200; fpu_is_fp = 1'b1;
        do_reset();
        while ((md_left > 0 || fpu_left > 0) && k < 10) begin
            md_valid  = (md_left > 0);
            md_data   = 64'h100 + 64'(2 - md_left);
            fpu_valid = (fpu_left > 0);
            fpu_data  = 64'h200 + 64'(2 - fpu_left);
            #1;
            obs = md_ready ? 1 : (fpu_ready ? 2 : 0);
            n_cmp++;
            if (k < 4 && obs !== order[k]) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got grant %0d, want %0d", k, obs, order[k]);
            end
            tick();
            if (g_md)  md_left--;
            if (g_fpu) fpu_left--;
            e = exp_q.pop_front();
            n_cmp++;
            if ({write, w1_addr, inp_data, sel_i_f, retired_cnt} !== e) begin
                n_fail++;
                $display("FAIL rr_out[%0d]: got wr=%0b addr=%0d data=%h sel=%0b cnt=%0d, want wr=%0b addr=%0d data=%h sel=%0b cnt=%0d",
                         k, write, w1_addr, inp_data, sel_i_f, retired_cnt, e.wr, e.addr, e.data, e.sel, e.cnt);
            end
            k++;
        end
        idle_inputs();
        n_cmp++;
        if (k !== 4 || retired_cnt !== 4'd4) begin
            n_fail++;
            $display("FAIL rr_total: got cycles=%0d cnt=%0d, want cycles=4 cnt=4", k, retired_cnt);
        end
    endtask

    task automatic test_alu_priority();
        logic [1:0] exp_rdy[5] = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b00};
        out_t e;
        idle_inputs();
        do_reset();
        md_addr = 5'd3; md_data = 64'h33; fpu_addr = 5'd4; fpu_data = 64'h44; fpu_is_fp = 1'b0;
        for (int i = 0; i < 5; i++) begin
            alu_valid = (i < 2);
            alu_addr  = 5'(10 + i);
            alu_data  = 64'hA0 + 64'(i);
            md_valid  = (i < 3);
            fpu_valid = (i < 4);
            #1;
            n_cmp++;
            if ({md_ready, fpu_ready} !== exp_rdy[i]) begin
                n_fail++;
                $display("FAIL prio_ready[%0d]: got md=%0b fpu=%0b, want %b", i, md_ready, fpu_ready, exp_rdy[i]);
            end
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if ({write, w1_addr, inp_data, sel_i_f, retired_cnt} !== e) begin
                n_fail++;
                $display("FAIL prio_out[%0d]: got wr=%0b addr=%0d data=%h sel=%0b cnt=%0d, want wr=%0b addr=%0d data=%h sel=%0b cnt=%0d",
                         i, write, w1_addr, inp_data, sel_i_f, retired_cnt, e.wr, e.addr, e.data, e.sel, e.cnt);
            end
        end
        idle_inputs();
    endtask

    task automatic test_wrap();
        out_t e;
        idle_inputs();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 64'(i) + 64'h1000;
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if ({write, w1_addr, inp_data, sel_i_f, retired_cnt} !== e) begin
                n_fail++;
                $display("FAIL wrap_out[%0d]: got wr=%0b addr=%0d data=%h sel=%0b cnt=%0d, want wr=%0b addr=%0d data=%h sel=%0b cnt=%0d",
                         i, write, w1_addr, inp_data, sel_i_f, retired_cnt, e.wr, e.addr, e.data, e.sel, e.cnt);
            end
        end
        idle_inputs();
        n_cmp++;
        if (retired_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d, want 1", retired_cnt);
        end
    endtask

    task automatic test_midop_reset();
        out_t e;
        idle_inputs();
        alu_valid = 1'b1; alu_addr = 5'd12; alu_data = 64'hCAFE;
        tick();
        e = exp_q.pop_front();
        n_cmp++;
        if ({write, w1_addr, inp_data} !== {1'b1, 5'd12, 64'hCAFE} || e.wr !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre: got wr=%0b addr=%0d data=%h, want wr=1 addr=12 data=cafe", write, w1_addr, inp_data);
        end
        idle_inputs();
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({write, w1_addr, retired_cnt} !== {1'b0, 5'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL midrst_async: got wr=%0b addr=%0d cnt=%0d, want 0 0 0", write, w1_addr, retired_cnt);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (write !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_hold: got wr=%0b, want 0", write);
        end
        rst = 1'b1;
        model_reset();
        tick();
        e = exp_q.pop_front();
        n_cmp++;
        if ({write, w1_addr, inp_data, sel_i_f, retired_cnt} !== e) begin
            n_fail++;
            $display("FAIL midrst_after: got wr=%0b addr=%0d data=%h sel=%0b cnt=%0d, want wr=%0b addr=%0d data=%h sel=%0b cnt=%0d",
                     write, w1_addr, inp_data, sel_i_f, retired_cnt, e.wr, e.addr, e.data, e.sel, e.cnt);
        end
    endtask

    initial begin
        test_reset();
        test_writes();
        test_round_robin();
        test_alu_priority();
        test_wrap();
        test_midop_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
